// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial adder/subtractor: one shared 4-bit ripple adder walks the
// operands a nibble per cycle, with a valid/ready handshake on each side.
module nibble_serial_add_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_valid,
    output logic                   start_ready,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    input  logic                   sub,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [4*NIBBLES-1:0]   sum,
    output logic                   cout,
    output logic                   ovf,
    output logic                   busy
);
    localparam int W    = 4 * NIBBLES;
    localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]      state_reg;
    logic [IDXW-1:0] idx_reg;
    logic            carry_reg;
    logic [W-1:0]    opa_reg;
    logic [W-1:0]    opb_reg;
    logic [W-1:0]    sum_reg;
    logic            cout_reg;
    logic            ovf_reg;

    logic [W-1:0]    opa_shift;
    logic [W-1:0]    opb_shift;
    logic [3:0]      opa_nib;
    logic [3:0]      opb_nib;
    logic [3:0]      nib_sum;
    logic [4:0]      carry_chain;
    logic [W-1:0]    sum_next;

    // Current nibble is brought down to bits [3:0] by shifting 4*idx.
    assign opa_shift = opa_reg >> {idx_reg, 2'b00};
    assign opb_shift = opb_reg >> {idx_reg, 2'b00};
    assign opa_nib   = opa_shift[3:0];
    assign opb_nib   = opb_shift[3:0];

    assign carry_chain[0] = carry_reg;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_fa
            assign nib_sum[gi]       = opa_nib[gi] ^ opb_nib[gi] ^ carry_chain[gi];
            assign carry_chain[gi+1] = (opa_nib[gi] & opb_nib[gi])
                                     | (carry_chain[gi] & (opa_nib[gi] ^ opb_nib[gi]));
        end
    endgenerate

    // Only the nibble addressed by idx is replaced; the others keep their value.
    always_comb begin
        sum_next = sum_reg;
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx_reg == IDXW'(i)) begin
                sum_next[4*i +: 4] = nib_sum;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            carry_reg <= 1'b0;
            opa_reg   <= '0;
            opb_reg   <= '0;
            sum_reg   <= '0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start_valid) begin
                        opa_reg   <= a;
                        opb_reg   <= sub ? ~b : b;
                        carry_reg <= sub;
                        idx_reg   <= '0;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    sum_reg   <= sum_next;
                    carry_reg <= carry_chain[4];
                    if (idx_reg == LAST_IDX) begin
                        cout_reg  <= carry_chain[4];
                        ovf_reg   <= carry_chain[3] ^ carry_chain[4];
                        idx_reg   <= '0;
                        state_reg <= DONE;
                    end else begin
                        idx_reg <= idx_reg + 1'b1;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign start_ready = (state_reg == IDLE);
    assign busy        = (state_reg == RUN);
    assign res_valid   = (state_reg == DONE);
    assign sum         = sum_reg;
    assign cout        = cout_reg;
    assign ovf         = ovf_reg;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Self-checking bench for nibble_serial_add_ctrl (NIBBLES=4): directed corner
// cases, stall/reset behaviour and 1000 random back-to-back operations.
module tb_nibble_serial_add_ctrl;
    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start_valid;
    logic         start_ready;
    logic [W-1:0] a_i;
    logic [W-1:0] b_i;
    logic         sub_i;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sb;
        logic [W-1:0] s;
        logic         c;
        logic         o;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    nibble_serial_add_ctrl #(.NIBBLES(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a           (a_i),
        .b           (b_i),
        .sub         (sub_i),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .sum         (sum),
        .cout        (cout),
        .ovf         (ovf),
        .busy        (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed views.
    task automatic ref_op(input logic [W-1:0] ra, input logic [W-1:0] rb, input logic rs,
                          output logic [W-1:0] s, output logic c, output logic o);
        int sa, sb, sr;
        int ua, ub;
        sa = $signed(ra);
        sb = $signed(rb);
        ua = int'(ra);
        ub = int'(rb);
        if (rs) begin
            s  = W'(ua - ub);
            c  = (ua >= ub);
            sr = sa - sb;
        end else begin
            s  = W'(ua + ub);
            c  = (ua + ub) > 32'hFFFF;
            sr = sa + sb;
        end
        o = (sr > 32767) || (sr < -32768);
    endtask

    // One full transaction; hold>0 stalls res_ready and pokes start_valid meanwhile.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ts,
                          input int hold, input string tag);
        logic [W-1:0] es;
        logic         ec, eo;
        int           lat, busy_cnt;
        ref_op(ta, tb, ts, es, ec, eo);
        @(posedge clk); #1;
        check({tag, "_ready_idle"}, start_ready, 1);
        a_i = ta; b_i = tb; sub_i = ts; start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = (hold > 0);
        a_i = W'($urandom); b_i = W'($urandom); sub_i = 1'($urandom);
        lat = 0;
        busy_cnt = 0;
        while (!res_valid && lat < 20) begin
            if (busy) busy_cnt++;
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, lat, N);
        check({tag, "_busy_cycles"}, busy_cnt, N);
        check({tag, "_sum"}, sum, es);
        check({tag, "_cout"}, cout, ec);
        check({tag, "_ovf"}, ovf, eo);
        for (int i = 0; i < hold; i++) begin
            a_i = W'($urandom); b_i = W'($urandom);
            @(posedge clk); #1;
            check({tag, "_hold_valid"}, res_valid, 1);
            check({tag, "_hold_sum"}, sum, es);
            check({tag, "_hold_ready"}, start_ready, 0);
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        start_valid = 1'b0;
        check({tag, "_idle_ready"}, start_ready, 1);
        check({tag, "_idle_valid"}, res_valid, 0);
        check({tag, "_idle_busy"}, busy, 0);
        check({tag, "_retain_sum"}, sum, es);
        check({tag, "_retain_cout"}, cout, ec);
        $display("op %s a=%04h b=%04h sub=%0d -> sum=%04h cout=%0d ovf=%0d lat=%0d",
                 tag, ta, tb, ts, sum, cout, ovf, lat);
    endtask

    initial begin
        exp_t         e;
        logic [W-1:0] es;
        logic         ec, eo;
        int           acc, done_n, cyc;
        logic         newop;

        rst_n = 1'b0; start_valid = 1'b0; res_ready = 1'b0;
        a_i = '0; b_i = '0; sub_i = 1'b0;
        #2;
        check("rst_start_ready", start_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        check("rst_ovf", ovf, 0);
        #20 rst_n = 1'b1;

        run_op(16'h1234, 16'h4321, 1'b0, 0, "add_5555");
        run_op(16'hFFFF, 16'h0001, 1'b0, 0, "ripple");
        run_op(16'h7FFF, 16'h0001, 1'b0, 0, "ovf_pos");
        run_op(16'h0003, 16'h0005, 1'b1, 0, "sub_neg");
        run_op(16'h8000, 16'h0001, 1'b1, 0, "ovf_sub");
        run_op(16'hA5C3, 16'h5A3C, 1'b0, 10, "stall");

        // Abort mid-run at idx=2.
        @(posedge clk); #1;
        a_i = 16'h1234; b_i = 16'h4321; sub_i = 1'b0; start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        check("abort_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        check("abort_start_ready", start_ready, 1);
        check("abort_busy", busy, 0);
        check("abort_res_valid", res_valid, 0);
        check("abort_sum", sum, 0);
        check("abort_cout", cout, 0);
        check("abort_ovf", ovf, 0);
        @(posedge clk); #1;
        check("abort_hold_valid", res_valid, 0);
        rst_n = 1'b1;
        run_op(16'h0001, 16'h0001, 1'b0, 0, "after_abort");
        check("after_abort_two", sum, 16'h0002);

        // Back-to-back random traffic with start_valid held high.
        acc = 0; done_n = 0; cyc = 0;
        @(posedge clk); #1;
        a_i = W'($urandom); b_i = W'($urandom); sub_i = 1'($urandom);
        start_valid = 1'b1; res_ready = 1'b1;
        while (done_n < 1000 && cyc < 20000) begin
            @(negedge clk);
            newop = 1'b0;
            if (start_valid && start_ready) begin
                ref_op(a_i, b_i, sub_i, es, ec, eo);
                e.a = a_i; e.b = b_i; e.sb = sub_i; e.s = es; e.c = ec; e.o = eo;
                exp_q.push_back(e);
                acc++;
                newop = 1'b1;
            end
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    check("rand_extra_result", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("rand_sum", sum, e.s);
                    check("rand_cout", cout, e.c);
                    check("rand_ovf", ovf, e.o);
                    done_n++;
                    $display("op rand%0d a=%04h b=%04h sub=%0d -> sum=%04h cout=%0d ovf=%0d",
                             done_n, e.a, e.b, e.sb, sum, cout, ovf);
                end
            end
            @(posedge clk); #1;
            cyc++;
            if (newop) begin
                a_i = W'($urandom); b_i = W'($urandom); sub_i = 1'($urandom);
                if (acc == 1000) start_valid = 1'b0;
            end
            res_ready = ($urandom_range(0, 3) != 0);
        end
        start_valid = 1'b0; res_ready = 1'b0;
        check("rand_done_count", done_n, 1000);
        check("rand_accept_count", acc, 1000);
        check("rand_queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/nibble_serial_add_ctrl.md
NIBBLE_SERIAL_ADD_CTRL -- requirements
Module: nibble_serial_add_ctrl

Interface
REQ-001 The block SHALL have parameter NIBBLES, default 4, giving the operand width W = 4*NIBBLES bits; legal range is 2..8.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port start_valid, input, 1, requester offers an operation.
REQ-005 The block SHALL have port start_ready, output, 1, block can accept an operation.
REQ-006 The block SHALL have port a, input, W, operand A.
REQ-007 The block SHALL have port b, input, W, operand B.
REQ-008 The block SHALL have port sub, input, 1, where 0 means A+B and 1 means A-B.
REQ-009 The block SHALL have port res_valid, output, 1, result available.
REQ-010 The block SHALL have port res_ready, input, 1, consumer takes the result.
REQ-011 The block SHALL have port sum, output, W, result.
REQ-012 The block SHALL have port cout, output, 1, unsigned carry out; for sub, 1 means no borrow (A >= B).
REQ-013 The block SHALL have port ovf, output, 1, two's-complement signed overflow.
REQ-014 The block SHALL have port busy, output, 1, high in RUN.

Function
REQ-015 The block SHALL contain exactly one 4-bit ripple-carry full-adder datapath (one 1-bit full-adder cell per bit), time-shared across nibbles.
REQ-016 The FSM SHALL have states IDLE, RUN and DONE, encoded as registers.
REQ-017 IDLE SHALL drive start_ready=1, busy=0 and res_valid=0; start_ready SHALL be 0 in every other state.
REQ-018 On start_valid & start_ready, the block SHALL:
- latch a into opA;
- latch b into opB, or ~b if sub=1;
- set carry register = sub;
- clear nibble index idx to 0;
- go to RUN.
REQ-019 a, b and sub SHALL be sampled only at the accept edge; changes during RUN or DONE SHALL have no effect.
REQ-020 Each RUN cycle SHALL:
- add opA[4*idx+3:4*idx] + opB[4*idx+3:4*idx] + carry;
- write the 4-bit sum into sum[4*idx+3:4*idx];
- store the nibble carry-out into the carry register;
- increment idx.
REQ-021 When idx = NIBBLES-1 in RUN, the same edge SHALL:
- load cout from the final carry-out;
- load ovf = carry-into-bit3 XOR carry-out-of-bit3 of that nibble;
- reset idx to 0;
- go to DONE.
REQ-022 Latency SHALL be exactly NIBBLES cycles from the accept edge to the edge that raises res_valid; for NIBBLES=4, accept at edge k gives res_valid high after edge k+4.
REQ-023 DONE SHALL hold res_valid=1 and keep sum, cout and ovf stable until res_valid & res_ready, then return to IDLE on that edge.
REQ-024 res_ready SHALL be ignored outside DONE.
REQ-025 start_valid SHALL be ignored outside IDLE, so no new operation is accepted in the cycle a result is consumed.
REQ-026 After returning to IDLE, sum, cout and ovf SHALL retain the last result until the next RUN starts overwriting sum nibble by nibble.
REQ-027 sum nibbles not yet written during RUN SHALL hold their prior values; consumers use sum only while res_valid=1.
REQ-028 The result SHALL be W-bit modulo 2^W; cout SHALL be the carry out of bit W-1.

Reset
REQ-029 While rst_n=0, the block SHALL immediately and asynchronously enter IDLE with the following reset values:
- idx=0, carry=0;
- opA=0, opB=0;
- sum=0, cout=0, ovf=0;
- res_valid=0, busy=0.
REQ-030 start_ready SHALL be 1 during and after reset.
REQ-031 Reset asserted during RUN or DONE SHALL abort the operation with no result delivered; the first accept after release SHALL start a fresh operation.

Verification
REQ-032 The bench SHALL cover: NIBBLES=4, a=16'h1234, b=16'h4321, sub=0 -> after 4 cycles sum=16'h5555, cout=0, ovf=0; busy is high for exactly 4 cycles.
REQ-033 The bench SHALL cover: a=16'hFFFF, b=16'h0001, sub=0 -> sum=16'h0000, cout=1, ovf=0 (carry ripples across all nibbles).
REQ-034 The bench SHALL cover: a=16'h7FFF, b=16'h0001, sub=0 -> sum=16'h8000, ovf=1, cout=0; and a=16'h0003, b=16'h0005, sub=1 -> sum=16'hFFFE, cout=0, ovf=0.
REQ-035 The bench SHALL cover: res_ready held low 10 cycles in DONE -> res_valid and sum stable throughout; start_valid pulsed during RUN/DONE is not accepted; raising res_ready gives IDLE next cycle.
REQ-036 The bench SHALL cover: rst_n asserted at RUN idx=2 -> outputs 0 and IDLE asynchronously; a new op a=16'h0001, b=16'h0001 after release -> sum=16'h0002.
REQ-037 The bench SHALL cover: back-to-back operations with start_valid held high -> each result consumed before the next accept, with no lost or duplicated operations over 1000 random operands checked against a W-bit reference sum.
